// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: word/address widths, named registers and
// the ALU control codes that decode hands to alu_32.
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_AT   = 5'd1;
  localparam logic [REG_ADDR_W-1:0] REG_V0   = 5'd2;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

  typedef enum logic [3:0] {
    ALU_AND = 4'h0,
    ALU_OR  = 4'h1,
    ALU_ADD = 4'h2,
    ALU_SUB = 4'h3,
    ALU_SLT = 4'h7,
    ALU_NOR = 4'hC
  } alu_ctrl_e;

  function automatic logic is_reg_zero(input logic [REG_ADDR_W-1:0] addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_32_if.sv
// Register-file access bus: two operand read ports, one write-back port and
// a debug read port for board display.
interface regfile_32_if
  import mips_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = REG_ADDR_W
);

  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [WIDTH-1:0]  rs_data;
  logic [WIDTH-1:0]  rt_data;
  logic              we;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic [ADDR_W-1:0] dbg_addr;
  logic [WIDTH-1:0]  dbg_data;

  modport master (
    output rs_addr, rt_addr, we, rd_addr, rd_data, dbg_addr,
    input  rs_data, rt_data, dbg_data
  );

  modport slave (
    input  rs_addr, rt_addr, we, rd_addr, rd_data, dbg_addr,
    output rs_data, rt_data, dbg_data
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: address mux over registers 1..DEPTH-1, with
// register 0 forced to zero and an optional same-cycle write bypass.
module regfile_read_port
  import mips_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0]                   addr,
  input  logic [(2**ADDR_W)-1:1][WIDTH-1:0]   regs,
  input  logic                                byp_en,
  input  logic [ADDR_W-1:0]                   byp_addr,
  input  logic [WIDTH-1:0]                    byp_data,
  output logic [WIDTH-1:0]                    data
);

  localparam int DEPTH = 2**ADDR_W;

  always_comb begin
    data = '0;
    if (addr != '0) begin
      for (int i = 1; i < DEPTH; i++) begin
        if (addr == ADDR_W'(i)) data = regs[i];
      end
      // byp_en already excludes address 0 and reset
      if ((BYPASS != 0) && byp_en && (addr == byp_addr)) data = byp_data;
    end
  end

endmodule

// File: rtl/regfile_32.sv
// 32 x 32 MIPS general-purpose register file. Register 0 is not stored and
// always reads zero; the debug port never sees bypassed write data.
module regfile_32
  import mips_pkg::*;
#(
  parameter int               WIDTH       = WORD_W,
  parameter int               ADDR_W      = REG_ADDR_W,
  parameter int               BYPASS      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic         clk,
  input logic         reset,
  regfile_32_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:1][WIDTH-1:0] regs;
  logic                        wr_en;

  assign wr_en = bus.we && !reset && (bus.rd_addr != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= {(DEPTH-1){RESET_VALUE}};
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wr_en && (bus.rd_addr == ADDR_W'(i))) regs[i] <= bus.rd_data;
      end
    end
  end

  regfile_read_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_rs (
    .addr     (bus.rs_addr),
    .regs     (regs),
    .byp_en   (wr_en),
    .byp_addr (bus.rd_addr),
    .byp_data (bus.rd_data),
    .data     (bus.rs_data)
  );

  regfile_read_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_rt (
    .addr     (bus.rt_addr),
    .regs     (regs),
    .byp_en   (wr_en),
    .byp_addr (bus.rd_addr),
    .byp_data (bus.rd_data),
    .data     (bus.rt_data)
  );

  regfile_read_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BYPASS(0)) u_port_dbg (
    .addr     (bus.dbg_addr),
    .regs     (regs),
    .byp_en   (1'b0),
    .byp_addr (bus.rd_addr),
    .byp_data (bus.rd_data),
    .data     (bus.dbg_data)
  );

endmodule

// File: tb/tb_regfile_32.sv
// Bench for regfile_32: a bypassing and a non-bypassing instance driven in
// parallel, directed vectors, reset corner cases and a random phase.
module tb_regfile_32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_32_if #(.WIDTH(32), .ADDR_W(5)) bus ();
  regfile_32_if #(.WIDTH(32), .ADDR_W(5)) bus_nb ();

  regfile_32 #(.WIDTH(32), .ADDR_W(5), .BYPASS(1), .RESET_VALUE(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  regfile_32 #(.WIDTH(32), .ADDR_W(5), .BYPASS(0), .RESET_VALUE(32'h0)) dut_nb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nb.slave)
  );

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dbg;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [31:0] e_dbg;
    logic [31:0] e_nb;
  } vec_t;

  vec_t        tbl[10];
  logic [31:0] model[32];
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dbg);
    bus.we = we;       bus_nb.we = we;
    bus.rd_addr = rd;  bus_nb.rd_addr = rd;
    bus.rd_data = wd;  bus_nb.rd_data = wd;
    bus.rs_addr = rs;  bus_nb.rs_addr = rs;
    bus.rt_addr = rt;  bus_nb.rt_addr = rt;
    bus.dbg_addr = dbg; bus_nb.dbg_addr = dbg;
  endtask

  // Advance past a rising edge and settle mid-cycle
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic model_write(input logic we, input logic [4:0] rd, input logic [31:0] wd);
    if (we && rd != 5'd0) model[rd] = wd;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic byp,
                                             input logic we, input logic [4:0] rd,
                                             input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (byp && we && rd == a) return wd;
    return model[a];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [32:0] sum;
    logic        rwe;
    logic [4:0]  rrd, rrs, rrt, rdbg;
    logic [31:0] rwd;

    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    tbl[0] = '{1'b1, 5'd5,  32'h00001234, 5'd5,  5'd6,  5'd5,  32'h00001234, 32'h0,        32'h0,        32'h0};
    tbl[1] = '{1'b1, 5'd6,  32'hFFFFFFFF, 5'd5,  5'd6,  5'd6,  32'h00001234, 32'hFFFFFFFF, 32'h0,        32'h00001234};
    tbl[2] = '{1'b0, 5'd6,  32'h0,        5'd5,  5'd6,  5'd6,  32'h00001234, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00001234};
    tbl[3] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
    tbl[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
    tbl[5] = '{1'b1, 5'd7,  32'h11111111, 5'd7,  5'd5,  5'd7,  32'h11111111, 32'h00001234, 32'h0,        32'h0};
    tbl[6] = '{1'b1, 5'd7,  32'h22222222, 5'd7,  5'd7,  5'd7,  32'h22222222, 32'h22222222, 32'h11111111, 32'h11111111};
    tbl[7] = '{1'b0, 5'd7,  32'h0,        5'd7,  5'd7,  5'd7,  32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222};
    tbl[8] = '{1'b1, 5'd31, 32'h00400020, 5'd31, 5'd31, 5'd31, 32'h00400020, 32'h00400020, 32'h0,        32'h0};
    tbl[9] = '{1'b0, 5'd31, 32'h0,        5'd31, 5'd31, 5'd31, 32'h00400020, 32'h00400020, 32'h00400020, 32'h00400020};

    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1 reset = 1'b1;
    #1;
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a), 5'(a));
      #1;
      check($sformatf("reset_rs[%0d]", a), bus.rs_data, 32'h0);
      check($sformatf("reset_rt[%0d]", 31 - a), bus.rt_data, 32'h0);
      check($sformatf("reset_dbg[%0d]", a), bus.dbg_data, 32'h0);
    end

    drive(1'b1, 5'd5, 32'h00001234, 5'd5, 5'd5, 5'd5);
    #1 check("write_in_reset_bypass", bus.rs_data, 32'h0);
    step();
    check("write_in_reset_rs", bus.rs_data, 32'h0);
    check("write_in_reset_dbg", bus.dbg_data, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
    reset = 1'b0;
    #1 check("after_release_r5", bus.dbg_data, 32'h0);
    step();

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].we, tbl[i].rd, tbl[i].wd, tbl[i].rs, tbl[i].rt, tbl[i].dbg);
      #1;
      check($sformatf("vec%0d_rs", i), bus.rs_data, tbl[i].e_rs);
      check($sformatf("vec%0d_rt", i), bus.rt_data, tbl[i].e_rt);
      check($sformatf("vec%0d_dbg", i), bus.dbg_data, tbl[i].e_dbg);
      check($sformatf("vec%0d_nobyp_rs", i), bus_nb.rs_data, tbl[i].e_nb);
      if (i == 2) begin
        sum = {1'b0, bus.rs_data} + {1'b0, bus.rt_data};
        check("alu_add_result", sum[31:0], 32'h00001233);
        check("alu_add_cout", {31'h0, sum[32]}, 32'h1);
      end
      step();
      model_write(tbl[i].we, tbl[i].rd, tbl[i].wd);
    end

    for (int n = 0; n < 300; n++) begin
      rwe  = 1'($urandom_range(0, 1));
      rrd  = 5'($urandom_range(0, 31));
      rwd  = $urandom;
      rrs  = ($urandom_range(0, 3) == 0) ? rrd : 5'($urandom_range(0, 31));
      rrt  = ($urandom_range(0, 3) == 0) ? rrd : 5'($urandom_range(0, 31));
      rdbg = ($urandom_range(0, 3) == 0) ? rrd : 5'($urandom_range(0, 31));
      drive(rwe, rrd, rwd, rrs, rrt, rdbg);
      #1;
      check("rand_rs", bus.rs_data, model_read(rrs, 1'b1, rwe, rrd, rwd));
      check("rand_rt", bus.rt_data, model_read(rrt, 1'b1, rwe, rrd, rwd));
      check("rand_dbg", bus.dbg_data, model_read(rdbg, 1'b0, rwe, rrd, rwd));
      check("rand_nobyp_rs", bus_nb.rs_data, model_read(rrs, 1'b0, rwe, rrd, rwd));
      step();
      model_write(rwe, rrd, rwd);
    end

    for (int r = 1; r < 32; r++) begin
      drive(1'b1, 5'(r), 32'(r), 5'd0, 5'd0, 5'd0);
      step();
      model_write(1'b1, 5'(r), 32'(r));
    end
    drive(1'b0, 5'd0, 32'h0, 5'd12, 5'd3, 5'd31);
    #1;
    check("fill_r12", bus.rs_data, model[12]);
    check("fill_r3", bus.rt_data, 32'd3);
    check("fill_r31", bus.dbg_data, 32'd31);

    drive(1'b1, 5'd3, 32'hAAAA5555, 5'd3, 5'd3, 5'd3);
    #1;
    check("midop_bypass_rs", bus.rs_data, 32'hAAAA5555);
    check("midop_dbg_old", bus.dbg_data, 32'd3);
    reset = 1'b1;
    #1;
    check("async_reset_rs", bus.rs_data, 32'h0);
    check("async_reset_rt", bus.rt_data, 32'h0);
    check("async_reset_dbg", bus.dbg_data, 32'h0);
    check("async_reset_nobyp", bus_nb.rs_data, 32'h0);
    bus.rs_addr = 5'd10;
    #1 check("async_reset_r10", bus.rs_data, 32'h0);
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    step();
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd10, 5'd3);
    #1;
    check("post_reset_r3", bus.rs_data, 32'h0);
    check("post_reset_r10", bus.rt_data, 32'h0);
    step();
    check("post_reset_r3_edge", bus.dbg_data, 32'h0);

    drive(1'b1, 5'd4, 32'h00000055, 5'd0, 5'd0, 5'd4);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd3, 5'd4);
    #1;
    check("first_write_after_reset", bus.rs_data, 32'h00000055);
    check("first_write_dbg", bus.dbg_data, 32'h00000055);
    check("r3_still_zero", bus.rt_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_32.md
Name: regfile_32

Overview:
- 32-entry x 32-bit MIPS general-purpose register file.
- Sits directly upstream of alu_32: rs_data drives the ALU s operand and rt_data drives the ALU t operand.
- Write-back results, including the ALU result, return through the single write port.
- Two combinational read ports, one synchronous write port, optional same-cycle write-to-read bypass, and a debug read port for FPGA board display.

Parameters:
- WIDTH, 32: data width of each register.
- ADDR_W, 5: register address width; depth is 2**ADDR_W.
- BYPASS, 1: 1 means a read returns the write data being written at the same clock edge; 0 means a read returns the stored value only.
- RESET_VALUE, 0: value loaded into every register on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears every register immediately.
- rs_addr  input  ADDR_W  read port A address.
- rt_addr  input  ADDR_W  read port B address.
- rs_data  output  WIDTH  read port A data, to the ALU s operand.
- rt_data  output  WIDTH  read port B data, to the ALU t operand.
- we  input  1  write enable.
- rd_addr  input  ADDR_W  write address.
- rd_data  input  WIDTH  write data.
- dbg_addr  input  ADDR_W  debug read address.
- dbg_data  output  WIDTH  debug read data; never bypassed.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - While reset=1, all registers hold RESET_VALUE and writes are ignored.
  - With the default RESET_VALUE, rs_data, rt_data and dbg_data read 0 combinationally during reset.
  - Deassertion takes effect at the next rising edge; the first write can land on the first edge with reset=0.
- Register 0:
  - Reads always return 0, regardless of RESET_VALUE.
  - Writes to address 0 are discarded.
  - Bypass never applies to address 0.
- Write:
  - At the rising edge of clk, when we=1, reset=0 and rd_addr!=0, the register at rd_addr takes rd_data.
  - Write latency is 1 cycle: the value is visible on non-bypassed reads after that edge.
- Read:
  - Purely combinational from the address to the data, with zero latency.
  - Ports A, B and debug are independent; any port may address the same register at the same time, and each gets identical data.
- Bypass (BYPASS=1): if we=1, rd_addr!=0, reset=0 and rs_addr==rd_addr, then rs_data=rd_data in the same cycle. The same rule applies to rt_addr/rt_data.
  - This covers the MIPS write-back/decode same-cycle hazard.
- No bypass (BYPASS=0): the read returns the old value until the edge.
- Reset mid-write: if reset rises while we=1, the write is lost and the register stays RESET_VALUE.
- Width rules: addresses are unsigned. No sign handling or truncation is done; data passes through bit-exact.
- Implementation footprint: storage is 31 physical registers (address 0 is not stored) plus three read multiplexers, which fits FPGA LUT/FF resources.

Decomposition:
- Shared package mips_pkg holds:
  - WORD_W=32 and REG_ADDR_W=5.
  - Register constants REG_ZERO=0, REG_AT=1, REG_V0=2, REG_SP=29, REG_RA=31.
  - The ALU control codes AND=0x0, OR=0x1, ADD=0x2, SUB=0x3, SLT=0x7, NOR=0xC, reused by decode.
- One sub-module is natural: regfile_read_port.
  - Function: address-indexed mux, zero-register force, optional bypass compare.
  - Instantiated for port A and port B, and for the debug port with bypass disabled.

Test Plan:
- Reset, then read all 32 addresses on rs, rt and dbg → every read is 0x00000000. Then write r5 with reset held at 1 → r5 still reads 0.
- Write r5=0x00001234 and r6=0xFFFFFFFF on consecutive edges, then set rs_addr=5, rt_addr=6 → rs_data=0x00001234, rt_data=0xFFFFFFFF. Feed both to alu_32 with control=0x2 → result=0x00001233, cout=1.
- Write r0=0xDEADBEEF with we=1 and rs_addr=0 in the same cycle → rs_data=0 during that cycle and after the edge. No bypass on address 0.
- Bypass: r7 holds 0x11111111; drive we=1, rd_addr=7, rd_data=0x22222222, rs_addr=rt_addr=7 → rs_data=rt_data=0x22222222 before the edge, while dbg_addr=7 still shows 0x11111111. With BYPASS=0, rs_data shows 0x11111111 until the edge.
- Simultaneous reads: rs_addr=rt_addr=dbg_addr=31 after writing r31=0x00400020 → all three outputs show 0x00400020. Write r31=0x0 with we=0 → no change.
- Reset mid-operation: fill r1..r31 with their own index. Assert reset asynchronously between edges, with we=1 writing r3=0xAAAA5555 → all reads go to 0 immediately, without waiting for an edge, and r3 stays 0 after reset is released.
